// File: rtl/ripple_seq_pkg.sv
// Shared constants for the byte-serial wide adder: chunk width, FSM
// encodings and a constant-evaluable ceiling-log2 for sizing counters.
package ripple_seq_pkg;

    localparam int CHUNK_W = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Smallest r with 2**r >= value; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ripple_adder.sv
// Plain ripple-carry adder slice; the sequencer reuses one instance for
// every byte of the wide operands.
module ripple_adder #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] carry;

    assign carry[0] = cin;

    // One full adder per bit, carry rippling from bit 0 upwards.
    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_fa
            assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = carry[W];

endmodule

// File: rtl/ripple_add_sequencer.sv
// Wide adder that streams WIDTH-bit operands through one 8-bit ripple
// slice, LSB byte first, with the inter-byte carry held in a flop.
// Valid/ready on both sides; one operation in flight at a time.
module ripple_add_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);

    import ripple_seq_pkg::*;

    localparam int NUM_CHUNKS = WIDTH / CHUNK_W;
    // Keep the counter at least one bit wide so WIDTH=8 still elaborates.
    localparam int CNT_W = (clog2(NUM_CHUNKS) < 1) ? 1 : clog2(NUM_CHUNKS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

    generate
        if ((WIDTH % CHUNK_W) != 0 || WIDTH < CHUNK_W) begin : g_bad_width
            $error("ripple_add_sequencer: WIDTH must be a positive multiple of 8");
        end
    endgenerate

    logic [1:0]       state_reg,  state_next;
    logic [WIDTH-1:0] opa_reg,    opa_next;
    logic [WIDTH-1:0] opb_reg,    opb_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic             carry_reg,  carry_next;
    logic [CNT_W-1:0] cnt_reg,    cnt_next;

    logic [CHUNK_W-1:0] slice_sum;
    logic               slice_cout;
    logic [WIDTH-1:0]   opa_shift;
    logic [WIDTH-1:0]   opb_shift;
    logic [WIDTH-1:0]   result_shift;

    ripple_adder #(
        .W (CHUNK_W)
    ) u_slice (
        .a    (opa_reg[CHUNK_W-1:0]),
        .b    (opb_reg[CHUNK_W-1:0]),
        .cin  (carry_reg),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Byte-wise shifts: operands drain from the bottom, sums enter at the
    // top so that after NUM_CHUNKS steps the result is fully aligned.
    generate
        if (NUM_CHUNKS == 1) begin : g_single
            assign opa_shift    = '0;
            assign opb_shift    = '0;
            assign result_shift = slice_sum;
        end else begin : g_multi
            assign opa_shift    = {{CHUNK_W{1'b0}}, opa_reg[WIDTH-1:CHUNK_W]};
            assign opb_shift    = {{CHUNK_W{1'b0}}, opb_reg[WIDTH-1:CHUNK_W]};
            assign result_shift = {slice_sum, result_reg[WIDTH-1:CHUNK_W]};
        end
    endgenerate

    // Next-state and datapath update for accept, per-byte add and drain.
    always_comb begin
        state_next  = state_reg;
        opa_next    = opa_reg;
        opb_next    = opb_reg;
        result_next = result_reg;
        carry_next  = carry_reg;
        cnt_next    = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (in_valid) begin
                    opa_next    = in_a;
                    opb_next    = in_b;
                    carry_next  = in_cin;
                    cnt_next    = '0;
                    result_next = '0;
                    state_next  = ST_RUN;
                end
            end
            ST_RUN: begin
                opa_next    = opa_shift;
                opb_next    = opb_shift;
                result_next = result_shift;
                carry_next  = slice_cout;
                cnt_next    = cnt_reg + CNT_W'(1);
                if (cnt_reg == LAST_CNT) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            opa_reg    <= '0;
            opb_reg    <= '0;
            result_reg <= '0;
            carry_reg  <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            opa_reg    <= opa_next;
            opb_reg    <= opb_next;
            result_reg <= result_next;
            carry_reg  <= carry_next;
            cnt_reg    <= cnt_next;
        end
    end

    // in_ready depends only on state (and reset), never on out_ready.
    assign in_ready  = (state_reg == ST_IDLE) && !rst;
    assign out_valid = (state_reg == ST_DONE);
    // Gate the result so partial sums never leak out during RUN.
    assign out_sum   = out_valid ? result_reg : '0;
    assign out_cout  = out_valid & carry_reg;
    assign busy      = (state_reg == ST_RUN) || (state_reg == ST_DONE);

endmodule

// File: tb/tb_ripple_add_sequencer.sv
// Directed and randomized checks of the byte-serial wide adder, with a
// 32-bit instance for most cases and an 8-bit instance for the
// single-chunk build.
module tb_ripple_add_sequencer;

    logic        clk;
    logic        rst;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_cout;
    logic        busy;

    logic        v8_in_valid;
    logic        v8_in_ready;
    logic [7:0]  v8_in_a;
    logic [7:0]  v8_in_b;
    logic        v8_in_cin;
    logic        v8_out_valid;
    logic        v8_out_ready;
    logic [7:0]  v8_out_sum;
    logic        v8_out_cout;
    logic        v8_busy;

    int checks = 0;
    int errors = 0;

    ripple_add_sequencer #(.WIDTH(32)) dut32 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
    );

    ripple_add_sequencer #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v8_in_valid),
        .in_ready  (v8_in_ready),
        .in_a      (v8_in_a),
        .in_b      (v8_in_b),
        .in_cin    (v8_in_cin),
        .out_valid (v8_out_valid),
        .out_ready (v8_out_ready),
        .out_sum   (v8_out_sum),
        .out_cout  (v8_out_cout),
        .busy      (v8_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One full 32-bit operation with exact latency and drain checks.
    task automatic op32(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic [31:0] exp_sum, input logic exp_cout);
        @(negedge clk);
        check({tag, "_ready_pre"}, 64'(in_ready), 64'd1);
        in_a      = a;
        in_b      = b;
        in_cin    = cin;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = 32'hA5A5A5A5;
        in_b     = 32'h5A5A5A5A;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_run%0d_valid", tag, i), 64'(out_valid), 64'd0);
            check($sformatf("%s_run%0d_sum", tag, i), 64'(out_sum), 64'd0);
            @(negedge clk);
        end
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_sum"}, 64'(out_sum), 64'(exp_sum));
        check({tag, "_cout"}, 64'(out_cout), 64'(exp_cout));
        check({tag, "_busy"}, 64'(busy), 64'd1);
        $display("op %s: a=0x%08h b=0x%08h cin=%0d -> sum=0x%08h cout=%0d", tag, a, b, cin, out_sum, out_cout);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_post_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_post_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [32:0] q[$];
        logic [32:0] exp_val;
        int cycles;
        int sent;
        int got;

        rst          = 1'b1;
        in_valid     = 1'b0;
        in_a         = '0;
        in_b         = '0;
        in_cin       = 1'b0;
        out_ready    = 1'b0;
        v8_in_valid  = 1'b0;
        v8_in_a      = '0;
        v8_in_b      = '0;
        v8_in_cin    = 1'b0;
        v8_out_ready = 1'b0;

        // Reset state
        @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_sum", 64'(out_sum), 64'd0);
        check("rst_out_cout", 64'(out_cout), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        #1;
        check("rst_release_ready", 64'(in_ready), 64'd1);

        // Directed 32-bit operations
        op32("t1_carry8", 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0);
        op32("t2_ripple_all", 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1);

        // Backpressure: result held, new in_valid ignored while in DONE
        @(negedge clk);
        in_a      = 32'h12345678;
        in_b      = 32'h11111111;
        in_cin    = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("t3_valid", 64'(out_valid), 64'd1);
        in_valid = 1'b1;
        in_a     = 32'hDEADBEEF;
        in_b     = 32'h00000001;
        in_cin   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("t3_hold%0d_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("t3_hold%0d_sum", i), 64'(out_sum), 64'h23456789);
            check($sformatf("t3_hold%0d_cout", i), 64'(out_cout), 64'd0);
            check($sformatf("t3_hold%0d_ready", i), 64'(in_ready), 64'd0);
        end
        $display("op t3_backpressure: sum=0x%08h after 5 stalled cycles", out_sum);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("t3_post_ready", 64'(in_ready), 64'd1);
        check("t3_post_valid", 64'(out_valid), 64'd0);
        check("t3_post_busy", 64'(busy), 64'd0);
        check("t3_post_sum", 64'(out_sum), 64'd0);

        // Reset asserted mid-RUN aborts the operation
        @(negedge clk);
        in_a     = 32'h80000000;
        in_b     = 32'h80000000;
        in_cin   = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t4_rst_busy", 64'(busy), 64'd0);
        check("t4_rst_valid", 64'(out_valid), 64'd0);
        check("t4_rst_sum", 64'(out_sum), 64'd0);
        check("t4_rst_cout", 64'(out_cout), 64'd0);
        check("t4_rst_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t4_release_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("t4_no_result%0d", i), 64'(out_valid), 64'd0);
        end
        $display("op t4_reset_abort: no result emitted");
        op32("t4_after_rst", 32'd5, 32'd7, 1'b0, 32'd12, 1'b0);

        // Single-chunk build: one RUN cycle
        @(negedge clk);
        check("t5_ready_pre", 64'(v8_in_ready), 64'd1);
        v8_in_a     = 8'hF0;
        v8_in_b     = 8'h20;
        v8_in_cin   = 1'b1;
        v8_in_valid = 1'b1;
        @(negedge clk);
        v8_in_valid = 1'b0;
        check("t5_run_valid", 64'(v8_out_valid), 64'd0);
        check("t5_run_busy", 64'(v8_busy), 64'd1);
        @(negedge clk);
        check("t5_valid", 64'(v8_out_valid), 64'd1);
        check("t5_sum", 64'(v8_out_sum), 64'h11);
        check("t5_cout", 64'(v8_out_cout), 64'd1);
        $display("op t5_width8: sum=0x%02h cout=%0d", v8_out_sum, v8_out_cout);
        v8_out_ready = 1'b1;
        @(negedge clk);
        v8_out_ready = 1'b0;
        check("t5_post_valid", 64'(v8_out_valid), 64'd0);
        check("t5_post_ready", 64'(v8_in_ready), 64'd1);

        // Randomized stream against a reference model scoreboard
        cycles = 0;
        sent   = 0;
        got    = 0;
        while (got < 1000 && cycles < 60000) begin
            @(negedge clk);
            cycles++;
            in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            in_a      = $urandom;
            in_b      = $urandom;
            in_cin    = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            if (in_valid && in_ready) begin
                q.push_back({1'b0, in_a} + {1'b0, in_b} + 33'(in_cin));
                sent++;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("rand_unexpected_result", 64'd1, 64'd0);
                end else begin
                    exp_val = q.pop_front();
                    check($sformatf("rand_%0d", got), 64'({out_cout, out_sum}), 64'(exp_val));
                    $display("op rand_%0d: sum=0x%08h cout=%0d", got, out_sum, out_cout);
                    got++;
                end
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("rand_count", 64'(got), 64'd1000);
        check("rand_queue_empty", 64'(q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
